// File: rtl/wptr_full_ctrl_if.sv
// Write-side bundle between the write client, pointer
// synchroniser and RAM, and the write pointer/flag controller.
interface wptr_full_ctrl_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  write;
    logic                  clr_ovf;
    logic [ADDR_WIDTH:0]   rp2_wpt;
    logic [ADDR_WIDTH:0]   wpt;
    logic [ADDR_WIDTH-1:0] waddr;
    logic                  wen;
    logic                  wr_ack;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   wcount;
    logic                  overflow;

    modport master (
        output write, clr_ovf, rp2_wpt,
        input  wpt, waddr, wen, wr_ack, full,
        input  almost_full, wcount, overflow
    );

    modport slave (
        input  write, clr_ovf, rp2_wpt,
        output wpt, waddr, wen, wr_ack, full,
        output almost_full, wcount, overflow
    );
endinterface

// File: rtl/wptr_full_ctrl.sv
// Async FIFO write-side controller: binary/Gray write pointers,
// full, almost-full, occupancy, write ack and sticky overflow.
module wptr_full_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 14
) (
    input  logic             WCLK,
    input  logic             WRST,
    wptr_full_ctrl_if.slave  bus
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] AF_LVL = PW'(AF_LEVEL);

    logic [ADDR_WIDTH:0] r_wbin;
    logic [ADDR_WIDTH:0] r_wpt;
    logic [ADDR_WIDTH:0] r_wcount;
    logic                r_full;
    logic                r_af;
    logic                r_ack;
    logic                r_ovf;

    logic                w_accept;
    logic [ADDR_WIDTH:0] w_wbin_next;
    logic [ADDR_WIDTH:0] w_wgray_next;
    logic [ADDR_WIDTH:0] w_rbin;
    logic [ADDR_WIDTH:0] w_full_tgt;
    logic [ADDR_WIDTH:0] w_occ_next;

    assign w_accept     = bus.write & ~r_full;
    assign w_wbin_next  = r_wbin + {{ADDR_WIDTH{1'b0}}, w_accept};
    assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;

    // Full when our next Gray pointer is exactly one lap ahead
    // of the synchronised read pointer (top two bits inverted).
    assign w_full_tgt = {~bus.rp2_wpt[ADDR_WIDTH:ADDR_WIDTH-1],
                         bus.rp2_wpt[ADDR_WIDTH-2:0]};

    // Decode the synchronised read Gray pointer back to binary.
    always_comb begin
        w_rbin = '0;
        for (int i = 0; i <= ADDR_WIDTH; i++) begin
            w_rbin[i] = ^(bus.rp2_wpt >> i);
        end
    end

    assign w_occ_next = w_wbin_next - w_rbin;

    // Pointer, flag and counter registers; reset wins over all.
    always_ff @(posedge WCLK) begin
        if (WRST) begin
            r_wbin   <= '0;
            r_wpt    <= '0;
            r_wcount <= '0;
            r_full   <= 1'b0;
            r_af     <= 1'b0;
            r_ack    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_wbin   <= w_wbin_next;
            r_wpt    <= w_wgray_next;
            r_wcount <= w_occ_next;
            r_full   <= (w_wgray_next == w_full_tgt);
            r_af     <= (w_occ_next >= AF_LVL);
            r_ack    <= w_accept;
            r_ovf    <= (bus.write & r_full) | (r_ovf & ~bus.clr_ovf);
        end
    end

    assign bus.wpt         = r_wpt;
    assign bus.waddr       = r_wbin[ADDR_WIDTH-1:0];
    assign bus.wen         = w_accept;
    assign bus.wr_ack      = r_ack;
    assign bus.full        = r_full;
    assign bus.almost_full = r_af;
    assign bus.wcount      = r_wcount;
    assign bus.overflow    = r_ovf;
endmodule
